instruction_decode_stage: RTL and testbench
===========================================

Name: instruction_decode_stage

Overview:
- ID stage of the pipelined MIPS core, directly downstream of the instruction fetch stage; consumes the fetch IR and PC+4.
- Holds the 32x32 register file and decodes the main-control subset.
- Detects load-use hazards and drives the fetch-side write enables.
- Registers everything into the ID/EX pipeline register on posedge CLK.

Parameters:
- DATA_W, 32, datapath/register width
- STALL_CNT_W, 16, width of saturating stall counter

Ports:
- CLK  in  1  system clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- IR  in  32  instruction from fetch stage
- PC_plus4  in  32  fetch adder output
- IF_valid  in  1  IR holds a real instruction
- flush  in  1  branch/jump taken in EX; squash instruction in ID
- WB_write_enable  in  1  writeback register write
- WB_write_reg  in  5  writeback destination
- WB_write_data  in  DATA_W  writeback data
- PC_write_enable  out  1  fetch PC update enable
- IF_ID_write_enable  out  1  fetch IR latch enable
- ID_EX_valid  out  1  ID/EX holds a real instruction
- ID_EX_pc_plus4  out  32  registered PC_plus4
- ID_EX_read_data1, ID_EX_read_data2  out  DATA_W each  registered rs/rt operands
- ID_EX_imm  out  32  registered sign-extended immediate
- ID_EX_jump_target  out  32  {PC_plus4[31:28], IR[25:0], 2'b00}
- ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_shamt  out  5 each  registered fields
- ID_EX_funct  out  6  registered funct
- ID_EX_reg_dst, ID_EX_alu_src, ID_EX_mem_to_reg, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write, ID_EX_branch, ID_EX_jump  out  1 each  registered control
- ID_EX_alu_op  out  2  registered ALU op class
- ID_EX_illegal  out  1  unknown opcode flag
- stall_count  out  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (RESET=0, asynchronous): all ID_EX_* outputs 0, all 32 registers 0, stall_count 0.
  - ID_EX_valid=0 forces load_use=0, so PC_write_enable=IF_ID_write_enable=1.
- Register file:
  - r0 always reads 0.
  - Write at posedge when WB_write_enable=1 and WB_write_reg!=0.
  - Reads are combinational with same-cycle bypass: if WB writes the register being read (non-zero), the read returns WB_write_data.
- Decode on IR[31:26]:
  - 000000 R-type: reg_dst, reg_write, alu_op=10.
  - 100011 lw: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - 101011 sw: alu_src, mem_write, alu_op=00.
  - 000100 beq: branch, alu_op=01.
  - 001000 addi: alu_src, reg_write, alu_op=00.
  - 000010 j: jump.
  - Any other opcode: all controls 0, illegal=1, valid still 1.
  - IR=0 (sll $0) decodes as R-type; the write to r0 is harmless.
- Immediate is {{16{IR[15]}}, IR[15:0]}.
- uses_rt is 1 for R-type, sw and beq; 0 otherwise.
- load_use (combinational) = ID_EX_valid & ID_EX_mem_read & ID_EX_rt!=0 & (ID_EX_rt==IR[25:21] | (uses_rt & ID_EX_rt==IR[20:16])).
- Write enables: PC_write_enable = IF_ID_write_enable = ~load_use | flush.
- ID/EX load at posedge:
  - Bubble (all controls 0, valid 0, data/fields 0) if flush, or load_use, or ~IF_valid.
  - Otherwise: decoded instruction, valid=1.
- Priority: flush over load_use. On flush the fetch enables stay 1 so the redirect proceeds.
- A stall lasts exactly one cycle: the inserted bubble clears ID_EX_mem_read, and the same IR re-decodes next cycle with updated operands.
- stall_count increments on posedge when load_use & ~flush; it saturates at all-ones and does not wrap.
- Latency: ID/EX outputs reflect IR one posedge after IR is presented.

Test Plan:
- Reset then release; IR=0x8C080004 (lw $8,4($0)), IF_valid=1 -> after 1 posedge: valid=1, mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, rt=8, imm=4.
- WB writes r9=0xDEADBEEF in the same cycle ID reads rs=9 (IR=0x01294020 add $8,$9,$9) -> read_data1=read_data2=0xDEADBEEF.
  - Also write r0=5, then read r0 -> returns 0.
- lw $8 then add $10,$8,$8 back-to-back:
  - Cycle after lw: PC_write_enable=0, IF_ID_write_enable=0, next ID/EX is a bubble (valid=0), stall_count=1.
  - Following cycle: add enters ID/EX with valid=1.
- Same load-use condition with flush=1 -> enables stay 1, ID/EX bubble, stall_count unchanged.
- IR=0xFC000000 -> illegal=1, all controls 0.
  - IR=0x08000010 with PC_plus4=0x40000004 -> jump=1, jump_target=0x40000040.
- Assert RESET low mid-stall (between posedges) -> outputs clear immediately, PC_write_enable returns to 1.
  - Separately, force 65535 stalls -> stall_count holds 0xFFFF.

Source files
------------

// File: rtl/instruction_decode_stage_if.sv
// Fetch-to-decode bus of the MIPS ID stage: fetch IR/PC, writeback port,
// fetch-side enables and the ID/EX pipeline register contents.
interface instruction_decode_stage_if #(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
);
  logic [31:0]            IR;
  logic [31:0]            PC_plus4;
  logic                   IF_valid;
  logic                   flush;
  logic                   WB_write_enable;
  logic [4:0]             WB_write_reg;
  logic [DATA_W-1:0]      WB_write_data;
  logic                   PC_write_enable;
  logic                   IF_ID_write_enable;
  logic                   ID_EX_valid;
  logic [31:0]            ID_EX_pc_plus4;
  logic [DATA_W-1:0]      ID_EX_read_data1;
  logic [DATA_W-1:0]      ID_EX_read_data2;
  logic [31:0]            ID_EX_imm;
  logic [31:0]            ID_EX_jump_target;
  logic [4:0]             ID_EX_rs;
  logic [4:0]             ID_EX_rt;
  logic [4:0]             ID_EX_rd;
  logic [4:0]             ID_EX_shamt;
  logic [5:0]             ID_EX_funct;
  logic                   ID_EX_reg_dst;
  logic                   ID_EX_alu_src;
  logic                   ID_EX_mem_to_reg;
  logic                   ID_EX_reg_write;
  logic                   ID_EX_mem_read;
  logic                   ID_EX_mem_write;
  logic                   ID_EX_branch;
  logic                   ID_EX_jump;
  logic [1:0]             ID_EX_alu_op;
  logic                   ID_EX_illegal;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output IR, PC_plus4, IF_valid, flush, WB_write_enable, WB_write_reg, WB_write_data,
    input  PC_write_enable, IF_ID_write_enable, ID_EX_valid, ID_EX_pc_plus4,
           ID_EX_read_data1, ID_EX_read_data2, ID_EX_imm, ID_EX_jump_target,
           ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_shamt, ID_EX_funct,
           ID_EX_reg_dst, ID_EX_alu_src, ID_EX_mem_to_reg, ID_EX_reg_write,
           ID_EX_mem_read, ID_EX_mem_write, ID_EX_branch, ID_EX_jump,
           ID_EX_alu_op, ID_EX_illegal, stall_count
  );

  modport slave (
    input  IR, PC_plus4, IF_valid, flush, WB_write_enable, WB_write_reg, WB_write_data,
    output PC_write_enable, IF_ID_write_enable, ID_EX_valid, ID_EX_pc_plus4,
           ID_EX_read_data1, ID_EX_read_data2, ID_EX_imm, ID_EX_jump_target,
           ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_shamt, ID_EX_funct,
           ID_EX_reg_dst, ID_EX_alu_src, ID_EX_mem_to_reg, ID_EX_reg_write,
           ID_EX_mem_read, ID_EX_mem_write, ID_EX_branch, ID_EX_jump,
           ID_EX_alu_op, ID_EX_illegal, stall_count
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: register file with WB bypass, main-control decode,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode_stage #(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input logic                    CLK,
  input logic                    RESET,
  instruction_decode_stage_if.slave bus
);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc_plus4;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [31:0]       imm;
    logic [31:0]       jump_target;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [1:0]        alu_op;
    logic              illegal;
  } id_ex_t;

  logic [DATA_W-1:0]      regs_r [32];
  logic [STALL_CNT_W-1:0] stall_count_r;
  id_ex_t                 id_ex_r;
  id_ex_t                 dec_s;
  id_ex_t                 id_ex_next_s;
  logic [4:0]             rs_s;
  logic [4:0]             rt_s;
  logic                   uses_rt_s;
  logic                   load_use_s;
  logic                   bubble_s;

  assign rs_s = bus.IR[25:21];
  assign rt_s = bus.IR[20:16];

  // Field extraction, operand read with same-cycle WB bypass, and main control decode
  always_comb begin
    dec_s             = '0;
    uses_rt_s         = 1'b0;
    dec_s.valid       = 1'b1;
    dec_s.pc_plus4    = bus.PC_plus4;
    dec_s.imm         = {{16{bus.IR[15]}}, bus.IR[15:0]};
    dec_s.jump_target = {bus.PC_plus4[31:28], bus.IR[25:0], 2'b00};
    dec_s.rs          = rs_s;
    dec_s.rt          = rt_s;
    dec_s.rd          = bus.IR[15:11];
    dec_s.shamt       = bus.IR[10:6];
    dec_s.funct       = bus.IR[5:0];
    if (rs_s == 5'd0) begin
      dec_s.read_data1 = {DATA_W{1'b0}};
    end else if (bus.WB_write_enable && (bus.WB_write_reg == rs_s)) begin
      dec_s.read_data1 = bus.WB_write_data;
    end else begin
      dec_s.read_data1 = regs_r[rs_s];
    end
    if (rt_s == 5'd0) begin
      dec_s.read_data2 = {DATA_W{1'b0}};
    end else if (bus.WB_write_enable && (bus.WB_write_reg == rt_s)) begin
      dec_s.read_data2 = bus.WB_write_data;
    end else begin
      dec_s.read_data2 = regs_r[rt_s];
    end
    case (bus.IR[31:26])
      6'b000000: begin
        dec_s.reg_dst   = 1'b1;
        dec_s.reg_write = 1'b1;
        dec_s.alu_op    = 2'b10;
        uses_rt_s       = 1'b1;
      end
      6'b100011: begin
        dec_s.alu_src    = 1'b1;
        dec_s.mem_to_reg = 1'b1;
        dec_s.reg_write  = 1'b1;
        dec_s.mem_read   = 1'b1;
      end
      6'b101011: begin
        dec_s.alu_src   = 1'b1;
        dec_s.mem_write = 1'b1;
        uses_rt_s       = 1'b1;
      end
      6'b000100: begin
        dec_s.branch = 1'b1;
        dec_s.alu_op = 2'b01;
        uses_rt_s    = 1'b1;
      end
      6'b001000: begin
        dec_s.alu_src   = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      6'b000010: dec_s.jump = 1'b1;
      default:   dec_s.illegal = 1'b1;
    endcase
  end

  // Load-use hazard against the load sitting in ID/EX; flush overrides the stall
  always_comb begin
    load_use_s = bus.ID_EX_valid && bus.ID_EX_mem_read && (bus.ID_EX_rt != 5'd0) &&
                 ((bus.ID_EX_rt == rs_s) || (uses_rt_s && (bus.ID_EX_rt == rt_s)));
    bubble_s   = bus.flush || load_use_s || !bus.IF_valid;
    if (bubble_s) begin
      id_ex_next_s = '0;
    end else begin
      id_ex_next_s = dec_s;
    end
  end

  assign bus.PC_write_enable    = !load_use_s || bus.flush;
  assign bus.IF_ID_write_enable = !load_use_s || bus.flush;

  // Register file write port; r0 is never written
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else if (bus.WB_write_enable && (bus.WB_write_reg != 5'd0)) begin
      regs_r[bus.WB_write_reg] <= bus.WB_write_data;
    end
  end

  // ID/EX pipeline register and saturating stall counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      id_ex_r       <= '0;
      stall_count_r <= {STALL_CNT_W{1'b0}};
    end else begin
      id_ex_r <= id_ex_next_s;
      if (load_use_s && !bus.flush && (stall_count_r != STALL_MAX)) begin
        stall_count_r <= stall_count_r + STALL_ONE;
      end
    end
  end

  assign bus.ID_EX_valid       = id_ex_r.valid;
  assign bus.ID_EX_pc_plus4    = id_ex_r.pc_plus4;
  assign bus.ID_EX_read_data1  = id_ex_r.read_data1;
  assign bus.ID_EX_read_data2  = id_ex_r.read_data2;
  assign bus.ID_EX_imm         = id_ex_r.imm;
  assign bus.ID_EX_jump_target = id_ex_r.jump_target;
  assign bus.ID_EX_rs          = id_ex_r.rs;
  assign bus.ID_EX_rt          = id_ex_r.rt;
  assign bus.ID_EX_rd          = id_ex_r.rd;
  assign bus.ID_EX_shamt       = id_ex_r.shamt;
  assign bus.ID_EX_funct       = id_ex_r.funct;
  assign bus.ID_EX_reg_dst     = id_ex_r.reg_dst;
  assign bus.ID_EX_alu_src     = id_ex_r.alu_src;
  assign bus.ID_EX_mem_to_reg  = id_ex_r.mem_to_reg;
  assign bus.ID_EX_reg_write   = id_ex_r.reg_write;
  assign bus.ID_EX_mem_read    = id_ex_r.mem_read;
  assign bus.ID_EX_mem_write   = id_ex_r.mem_write;
  assign bus.ID_EX_branch      = id_ex_r.branch;
  assign bus.ID_EX_jump        = id_ex_r.jump;
  assign bus.ID_EX_alu_op      = id_ex_r.alu_op;
  assign bus.ID_EX_illegal     = id_ex_r.illegal;
  assign bus.stall_count       = stall_count_r;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage; a second instance with a
// 4-bit stall counter exercises saturation within a short run.
module tb_instruction_decode_stage;
  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  instruction_decode_stage_if #(.DATA_W(32), .STALL_CNT_W(16)) bus ();
  instruction_decode_stage #(.DATA_W(32), .STALL_CNT_W(16)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  instruction_decode_stage_if #(.DATA_W(32), .STALL_CNT_W(4)) sbus ();
  instruction_decode_stage #(.DATA_W(32), .STALL_CNT_W(4)) sdut (.CLK(CLK), .RESET(RESET), .bus(sbus));

  localparam logic [31:0] LW8   = 32'h8C08_0004; // lw  $8,4($0)
  localparam logic [31:0] ADD99 = 32'h0129_4020; // add $8,$9,$9
  localparam logic [31:0] ADD00 = 32'h0000_4020; // add $8,$0,$0
  localparam logic [31:0] ADD88 = 32'h0108_5020; // add $10,$8,$8
  localparam logic [10:0] C_R   = 11'b10010000100;
  localparam logic [10:0] C_LW  = 11'b01111000000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [10:0] ctrl_obs;
    return {bus.ID_EX_reg_dst, bus.ID_EX_alu_src, bus.ID_EX_mem_to_reg, bus.ID_EX_reg_write,
            bus.ID_EX_mem_read, bus.ID_EX_mem_write, bus.ID_EX_branch, bus.ID_EX_jump,
            bus.ID_EX_alu_op, bus.ID_EX_illegal};
  endfunction

  logic [31:0] tab_ir   [5] = '{32'hAC09_0008, 32'h1109_FFFF, 32'h2128_FFF0, 32'h0800_0010, 32'hFC00_0000};
  logic [10:0] tab_ctrl [5] = '{11'b01000100000, 11'b00000010010, 11'b01010000000,
                                11'b00000001000, 11'b00000000001};
  logic [31:0] tab_imm  [5] = '{32'h0000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000};

  initial begin
    bus.IR = 32'h0; bus.PC_plus4 = 32'h0; bus.IF_valid = 1'b0; bus.flush = 1'b0;
    bus.WB_write_enable = 1'b0; bus.WB_write_reg = 5'd0; bus.WB_write_data = 32'h0;
    sbus.IR = 32'h0; sbus.PC_plus4 = 32'h0; sbus.IF_valid = 1'b0; sbus.flush = 1'b0;
    sbus.WB_write_enable = 1'b0; sbus.WB_write_reg = 5'd0; sbus.WB_write_data = 32'h0;
    #12;
    chk("reset_valid", {31'h0, bus.ID_EX_valid}, 32'h0);
    chk("reset_ctrl", {21'h0, ctrl_obs()}, 32'h0);
    chk("reset_stall", {16'h0, bus.stall_count}, 32'h0);
    chk("reset_pc_we", {31'h0, bus.PC_write_enable}, 32'h1);
    RESET = 1'b1;

    bus.IR = LW8; bus.PC_plus4 = 32'h0000_0100; bus.IF_valid = 1'b1;
    tick;
    chk("lw_valid", {31'h0, bus.ID_EX_valid}, 32'h1);
    chk("lw_ctrl", {21'h0, ctrl_obs()}, {21'h0, C_LW});
    chk("lw_rt", {27'h0, bus.ID_EX_rt}, 32'd8);
    chk("lw_imm", bus.ID_EX_imm, 32'h4);
    chk("lw_pc", bus.ID_EX_pc_plus4, 32'h100);

    bus.IR = ADD99; bus.WB_write_enable = 1'b1; bus.WB_write_reg = 5'd9; bus.WB_write_data = 32'hDEAD_BEEF;
    #1;
    chk("no_hazard_pc_we", {31'h0, bus.PC_write_enable}, 32'h1);
    tick;
    chk("bypass_rd1", bus.ID_EX_read_data1, 32'hDEAD_BEEF);
    chk("bypass_rd2", bus.ID_EX_read_data2, 32'hDEAD_BEEF);
    chk("r_ctrl", {21'h0, ctrl_obs()}, {21'h0, C_R});
    chk("r_rd", {27'h0, bus.ID_EX_rd}, 32'd8);
    chk("r_funct", {26'h0, bus.ID_EX_funct}, 32'h20);

    bus.IR = ADD00; bus.WB_write_reg = 5'd0; bus.WB_write_data = 32'h5;
    tick;
    chk("r0_bypass_rd1", bus.ID_EX_read_data1, 32'h0);
    bus.WB_write_enable = 1'b0;
    tick;
    chk("r0_stored_rd2", bus.ID_EX_read_data2, 32'h0);
    bus.IR = ADD99;
    tick;
    chk("r9_stored", bus.ID_EX_read_data1, 32'hDEAD_BEEF);

    bus.PC_plus4 = 32'h4000_0004;
    for (int i = 0; i < 5; i++) begin
      bus.IR = tab_ir[i];
      tick;
      chk("tab_valid", {31'h0, bus.ID_EX_valid}, 32'h1);
      chk("tab_ctrl", {21'h0, ctrl_obs()}, {21'h0, tab_ctrl[i]});
      chk("tab_imm", bus.ID_EX_imm, tab_imm[i]);
    end
    bus.IR = 32'h0800_0010;
    tick;
    chk("jump_target", bus.ID_EX_jump_target, 32'h4000_0040);

    bus.IR = LW8;
    tick;
    bus.IR = ADD88;
    #1;
    chk("stall_pc_we", {31'h0, bus.PC_write_enable}, 32'h0);
    chk("stall_ifid_we", {31'h0, bus.IF_ID_write_enable}, 32'h0);
    tick;
    chk("stall_bubble", {31'h0, bus.ID_EX_valid}, 32'h0);
    chk("stall_count1", {16'h0, bus.stall_count}, 32'h1);
    chk("stall_release", {31'h0, bus.PC_write_enable}, 32'h1);
    tick;
    chk("after_stall_valid", {31'h0, bus.ID_EX_valid}, 32'h1);
    chk("after_stall_rd", {27'h0, bus.ID_EX_rd}, 32'd10);

    bus.IR = LW8;
    tick;
    bus.IR = ADD88; bus.flush = 1'b1;
    #1;
    chk("flush_pc_we", {31'h0, bus.PC_write_enable}, 32'h1);
    chk("flush_ifid_we", {31'h0, bus.IF_ID_write_enable}, 32'h1);
    tick;
    bus.flush = 1'b0;
    chk("flush_bubble", {31'h0, bus.ID_EX_valid}, 32'h0);
    chk("flush_stall_cnt", {16'h0, bus.stall_count}, 32'h1);

    bus.IR = LW8; bus.IF_valid = 1'b0;
    tick;
    chk("ifvalid_bubble", {31'h0, bus.ID_EX_valid}, 32'h0);
    chk("ifvalid_memrd", {31'h0, bus.ID_EX_mem_read}, 32'h0);
    bus.IF_valid = 1'b1;

    tick;
    bus.IR = ADD88;
    #1;
    chk("pre_reset_stall", {31'h0, bus.PC_write_enable}, 32'h0);
    #1 RESET = 1'b0;
    #1;
    chk("midreset_valid", {31'h0, bus.ID_EX_valid}, 32'h0);
    chk("midreset_ctrl", {21'h0, ctrl_obs()}, 32'h0);
    chk("midreset_stall", {16'h0, bus.stall_count}, 32'h0);
    chk("midreset_pc_we", {31'h0, bus.PC_write_enable}, 32'h1);
    @(negedge CLK);
    RESET = 1'b1;
    bus.IR = ADD99;
    tick;
    chk("regfile_cleared", bus.ID_EX_read_data1, 32'h0);

    sbus.IF_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sbus.IR = LW8; tick;
      sbus.IR = ADD88; tick;
    end
    chk("sat_mid", {28'h0, sbus.stall_count}, 32'h7);
    for (int i = 0; i < 10; i++) begin
      sbus.IR = LW8; tick;
      sbus.IR = ADD88; tick;
    end
    chk("sat_hold", {28'h0, sbus.stall_count}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
